// File: rtl/xlr_gpp_ctrl.sv
// GPP control block: shadow/active argument banks, launch/run/done handshake
// with the accelerator core, result capture, watchdog and level interrupt.
//
// state  | meaning
// IDLE   | waiting for host_start; shadow bank freely writable
// LAUNCH | active bank frozen, one-cycle xlr_start to core, watchdog cleared
// RUN    | core working; abort, completion or watchdog expiry leave this state
// DONE   | done_irq held until irq_clr
module xlr_gpp_ctrl #(
   parameter int DATA_W    = 32,
   parameter int NUM_REGS  = 16,
   parameter int TIMEOUT_W = 16,
   localparam int IDX_W    = $clog2(NUM_REGS)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         host_wr_en,
   input  logic [IDX_W-1:0]             host_wr_idx,
   input  logic [DATA_W-1:0]            host_wr_data,
   input  logic [IDX_W-1:0]             host_rd_idx,
   input  logic                         host_rd_src,
   output logic [DATA_W-1:0]            host_rd_data,
   input  logic                         host_start,
   input  logic                         host_abort,
   input  logic                         irq_clr,
   input  logic [TIMEOUT_W-1:0]         timeout_limit,
   output logic [NUM_REGS*DATA_W-1:0]   xlr_gpp_out,
   output logic                         xlr_start,
   input  logic                         xlr_done,
   input  logic [NUM_REGS*DATA_W-1:0]   xlr_gpp_in,
   output logic                         busy,
   output logic                         done_irq,
   output logic                         timeout_err,
   output logic                         start_drop
);

   typedef enum logic [1:0] {IDLE, LAUNCH, RUN, DONE} state_t;

   state_t               state, state_nxt;
   logic [DATA_W-1:0]    shadow [NUM_REGS];
   logic [DATA_W-1:0]    active [NUM_REGS];
   logic [DATA_W-1:0]    result [NUM_REGS];
   logic [TIMEOUT_W-1:0] wd_cnt;
   logic                 wd_expired;
   logic                 snap, capture, wd_clear, wd_inc, terr_set;

   assign wd_expired = (timeout_limit != '0) &&
                       (wd_cnt == timeout_limit - TIMEOUT_W'(1));

   always_comb begin
      state_nxt = state;
      snap      = 1'b0;
      capture   = 1'b0;
      wd_clear  = 1'b0;
      wd_inc    = 1'b0;
      terr_set  = 1'b0;
      case (state)
         IDLE: begin
            if (host_start) begin
               snap      = 1'b1;
               state_nxt = LAUNCH;
            end
         end
         LAUNCH: begin
            wd_clear  = 1'b1;
            state_nxt = RUN;
         end
         RUN: begin
            if (host_abort) begin
               state_nxt = IDLE;
            end else if (xlr_done) begin
               capture   = 1'b1;
               state_nxt = DONE;
            end else if (wd_expired) begin
               terr_set  = 1'b1;
               state_nxt = DONE;
            end else begin
               wd_inc = 1'b1;
            end
         end
         DONE: begin
            if (irq_clr) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         wd_cnt      <= '0;
         timeout_err <= 1'b0;
         start_drop  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (wd_clear)
            wd_cnt <= '0;
         else if (wd_inc && wd_cnt != '1)
            wd_cnt <= wd_cnt + TIMEOUT_W'(1);
         if (terr_set)
            timeout_err <= 1'b1;
         else if (irq_clr && state == DONE)
            timeout_err <= 1'b0;
         // a dropped start outranks a simultaneous clear so it is never lost
         if (host_start && state != IDLE)
            start_drop <= 1'b1;
         else if (irq_clr)
            start_drop <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            shadow[i] <= '0;
            active[i] <= '0;
            result[i] <= '0;
         end
         host_rd_data <= '0;
      end else begin
         host_rd_data <= host_rd_src ? result[host_rd_idx] : shadow[host_rd_idx];
         if (host_wr_en)
            shadow[host_wr_idx] <= host_wr_data;
         for (int i = 0; i < NUM_REGS; i++) begin
            // same-cycle host write is folded into the snapshot
            if (snap)
               active[i] <= (host_wr_en && host_wr_idx == IDX_W'(i)) ?
                            host_wr_data : shadow[i];
            if (capture)
               result[i] <= xlr_gpp_in[i*DATA_W +: DATA_W];
         end
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_pack
      assign xlr_gpp_out[g*DATA_W +: DATA_W] = active[g];
   end

   assign xlr_start = (state == LAUNCH);
   assign busy      = (state == LAUNCH) || (state == RUN);
   assign done_irq  = (state == DONE);

endmodule

// File: tb/tb_xlr_gpp_ctrl.sv
// Bench for xlr_gpp_ctrl: directed vector table, corner sequences and random
// traffic, all checked against a transaction-level reference model.
module tb_xlr_gpp_ctrl;

   localparam int DW = 32;
   localparam int NR = 16;
   localparam int TW = 16;
   localparam int IW = 4;

   logic            clk, rst_n;
   logic            host_wr_en;
   logic [IW-1:0]   host_wr_idx;
   logic [DW-1:0]   host_wr_data;
   logic [IW-1:0]   host_rd_idx;
   logic            host_rd_src;
   logic [DW-1:0]   host_rd_data;
   logic            host_start, host_abort, irq_clr;
   logic [TW-1:0]   timeout_limit;
   logic [NR*DW-1:0] xlr_gpp_out;
   logic            xlr_start;
   logic            xlr_done;
   logic [NR*DW-1:0] xlr_gpp_in;
   logic            busy, done_irq, timeout_err, start_drop;

   xlr_gpp_ctrl #(.DATA_W(DW), .NUM_REGS(NR), .TIMEOUT_W(TW)) dut (
      .clk(clk), .rst_n(rst_n),
      .host_wr_en(host_wr_en), .host_wr_idx(host_wr_idx), .host_wr_data(host_wr_data),
      .host_rd_idx(host_rd_idx), .host_rd_src(host_rd_src), .host_rd_data(host_rd_data),
      .host_start(host_start), .host_abort(host_abort), .irq_clr(irq_clr),
      .timeout_limit(timeout_limit), .xlr_gpp_out(xlr_gpp_out), .xlr_start(xlr_start),
      .xlr_done(xlr_done), .xlr_gpp_in(xlr_gpp_in), .busy(busy), .done_irq(done_irq),
      .timeout_err(timeout_err), .start_drop(start_drop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic             wr_en;
      logic [IW-1:0]    wr_idx;
      logic [DW-1:0]    wr_data;
      logic [IW-1:0]    rd_idx;
      logic             rd_src;
      logic             start, abort, clr, done;
      logic [TW-1:0]    limit;
      logic [NR*DW-1:0] gin;
   } in_t;

   typedef struct {
      in_t           i;
      logic          e_busy, e_start, e_irq, e_terr, e_drop;
      logic [DW-1:0] e_rd, e_w3;
   } vec_t;

   int n_chk = 0;
   int n_err = 0;

   // reference model: the spec's phases with a plain count of RUN cycles
   localparam int P_IDLE = 0, P_LAUNCH = 1, P_RUN = 2, P_DONE = 3;
   int            m_ph;
   int            m_runs;
   bit            m_terr, m_drop;
   logic [DW-1:0] m_sh [NR];
   logic [DW-1:0] m_act [NR];
   logic [DW-1:0] m_res [NR];
   logic [DW-1:0] m_rd;

   function automatic in_t blank(logic [TW-1:0] lim);
      in_t v;
      v.wr_en = 0; v.wr_idx = '0; v.wr_data = '0; v.rd_idx = '0; v.rd_src = 0;
      v.start = 0; v.abort = 0; v.clr = 0; v.done = 0; v.limit = lim; v.gin = '0;
      return v;
   endfunction

   function automatic in_t mk(logic we, int widx, logic [DW-1:0] wd, int ridx, logic src,
                              logic st, logic ab, logic cl, logic dn, logic [DW-1:0] g0);
      in_t v;
      v = blank('0);
      v.wr_en = we; v.wr_idx = IW'(widx); v.wr_data = wd;
      v.rd_idx = IW'(ridx); v.rd_src = src;
      v.start = st; v.abort = ab; v.clr = cl; v.done = dn;
      v.gin[DW-1:0] = g0;
      return v;
   endfunction

   task automatic model_reset();
      m_ph = P_IDLE; m_runs = 0; m_terr = 0; m_drop = 0; m_rd = '0;
      for (int k = 0; k < NR; k++) begin
         m_sh[k] = '0; m_act[k] = '0; m_res[k] = '0;
      end
   endtask

   task automatic model_step(in_t v);
      logic [DW-1:0] nsh [NR];
      int            ph0;
      ph0  = m_ph;
      m_rd = v.rd_src ? m_res[v.rd_idx] : m_sh[v.rd_idx];
      nsh  = m_sh;
      if (v.wr_en) nsh[v.wr_idx] = v.wr_data;
      case (ph0)
         P_IDLE: if (v.start) begin m_act = nsh; m_ph = P_LAUNCH; end
         P_LAUNCH: begin m_runs = 0; m_ph = P_RUN; end
         P_RUN: begin
            if (v.abort) m_ph = P_IDLE;
            else if (v.done) begin
               for (int k = 0; k < NR; k++) m_res[k] = v.gin[k*DW +: DW];
               m_ph = P_DONE;
            end else if (v.limit != 0 && m_runs + 1 == int'(v.limit)) begin
               m_terr = 1; m_ph = P_DONE;
            end else if (m_runs < 65535) m_runs++;
         end
         default: if (v.clr) begin m_ph = P_IDLE; m_terr = 0; end
      endcase
      if (v.start && ph0 != P_IDLE) m_drop = 1;
      else if (v.clr) m_drop = 0;
      m_sh = nsh;
   endtask

   task automatic chk(string nm, logic [NR*DW-1:0] act, logic [NR*DW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic check_model();
      logic [NR*DW-1:0] pk;
      for (int k = 0; k < NR; k++) pk[k*DW +: DW] = m_act[k];
      chk("gpp_out", xlr_gpp_out, pk);
      chk("xlr_start", xlr_start, m_ph == P_LAUNCH);
      chk("busy", busy, m_ph == P_LAUNCH || m_ph == P_RUN);
      chk("done_irq", done_irq, m_ph == P_DONE);
      chk("timeout_err", timeout_err, m_terr);
      chk("start_drop", start_drop, m_drop);
      chk("rd_data", host_rd_data, m_rd);
   endtask

   task automatic cyc(in_t v);
      host_wr_en = v.wr_en; host_wr_idx = v.wr_idx; host_wr_data = v.wr_data;
      host_rd_idx = v.rd_idx; host_rd_src = v.rd_src;
      host_start = v.start; host_abort = v.abort; irq_clr = v.clr;
      xlr_done = v.done; timeout_limit = v.limit; xlr_gpp_in = v.gin;
      @(posedge clk);
      model_step(v);
      #1;
      check_model();
   endtask

   vec_t tbl [14];
   in_t  v;

   initial begin
      rst_n = 0;
      cyc_init();
      model_reset();

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check_model();
      chk("rst_busy", busy, 1'b0);
      chk("rst_out", xlr_gpp_out, '0);
      rst_n = 1;

      // launch / complete / isolation / drop / abort table
      tbl[0]  = '{mk(1,3,32'hDEADBEEF,3,0,0,0,0,0,0), 0,0,0,0,0, 32'h0,        32'h0};
      tbl[1]  = '{mk(0,0,0,3,0,1,0,0,0,0),            1,1,0,0,0, 32'hDEADBEEF, 32'hDEADBEEF};
      tbl[2]  = '{mk(0,0,0,3,0,0,0,0,0,0),            1,0,0,0,0, 32'hDEADBEEF, 32'hDEADBEEF};
      tbl[3]  = '{mk(1,3,32'h1,3,0,0,0,0,0,0),        1,0,0,0,0, 32'hDEADBEEF, 32'hDEADBEEF};
      tbl[4]  = '{mk(0,0,0,3,0,0,0,0,0,0),            1,0,0,0,0, 32'h1,        32'hDEADBEEF};
      tbl[5]  = '{mk(0,0,0,3,0,1,0,0,0,0),            1,0,0,0,1, 32'h1,        32'hDEADBEEF};
      tbl[6]  = '{mk(0,0,0,0,1,0,0,0,1,32'h12345678), 0,0,1,0,1, 32'h0,        32'hDEADBEEF};
      tbl[7]  = '{mk(0,0,0,0,1,0,0,0,0,0),            0,0,1,0,1, 32'h12345678, 32'hDEADBEEF};
      tbl[8]  = '{mk(0,0,0,0,1,0,1,0,0,0),            0,0,1,0,1, 32'h12345678, 32'hDEADBEEF};
      tbl[9]  = '{mk(0,0,0,0,1,0,0,1,0,0),            0,0,0,0,0, 32'h12345678, 32'hDEADBEEF};
      tbl[10] = '{mk(0,0,0,3,0,1,0,0,0,0),            1,1,0,0,0, 32'h1,        32'h1};
      tbl[11] = '{mk(0,0,0,3,0,0,0,0,0,0),            1,0,0,0,0, 32'h1,        32'h1};
      tbl[12] = '{mk(0,0,0,3,0,0,1,0,0,0),            0,0,0,0,0, 32'h1,        32'h1};
      tbl[13] = '{mk(0,0,0,3,0,0,0,0,0,0),            0,0,0,0,0, 32'h1,        32'h1};
      for (int r = 0; r < 14; r++) begin
         cyc(tbl[r].i);
         chk($sformatf("tbl%0d_busy", r), busy, tbl[r].e_busy);
         chk($sformatf("tbl%0d_start", r), xlr_start, tbl[r].e_start);
         chk($sformatf("tbl%0d_irq", r), done_irq, tbl[r].e_irq);
         chk($sformatf("tbl%0d_terr", r), timeout_err, tbl[r].e_terr);
         chk($sformatf("tbl%0d_drop", r), start_drop, tbl[r].e_drop);
         chk($sformatf("tbl%0d_rd", r), host_rd_data, tbl[r].e_rd);
         chk($sformatf("tbl%0d_w3", r), xlr_gpp_out[3*DW +: DW], tbl[r].e_w3);
      end

      // watchdog expiry after the 10th RUN cycle
      v = blank(16'd10); v.start = 1; cyc(v);
      v.start = 0; cyc(v);
      repeat (9) cyc(v);
      chk("to_pre_irq", done_irq, 1'b0);
      chk("to_pre_busy", busy, 1'b1);
      cyc(v);
      chk("to_irq", done_irq, 1'b1);
      chk("to_terr", timeout_err, 1'b1);
      v.rd_src = 1; v.rd_idx = 0; cyc(v);
      chk("to_result_kept", host_rd_data, 32'h12345678);
      v.clr = 1; cyc(v); v.clr = 0;
      chk("to_clr_terr", timeout_err, 1'b0);

      // completion on the same edge the watchdog would fire
      v.start = 1; cyc(v);
      v.start = 0; cyc(v);
      repeat (9) cyc(v);
      v.done = 1; v.gin[DW-1:0] = 32'hCAFE0001; cyc(v); v.done = 0;
      chk("race_irq", done_irq, 1'b1);
      chk("race_terr", timeout_err, 1'b0);
      cyc(v);
      chk("race_result", host_rd_data, 32'hCAFE0001);
      v.clr = 1; cyc(v); v.clr = 0;

      // bypass: write and start in the same cycle
      v = blank('0); v.wr_en = 1; v.wr_idx = 7; v.wr_data = 32'hA5A5A5A5; v.start = 1; cyc(v);
      chk("bypass_w7", xlr_gpp_out[7*DW +: DW], 32'hA5A5A5A5);
      v = blank('0); cyc(v);
      v.abort = 1; cyc(v);
      chk("abort_irq", done_irq, 1'b0);

      // reset held mid-run
      v = blank('0); v.wr_en = 1; v.wr_idx = 5; v.wr_data = 32'h55; cyc(v);
      v = blank('0); v.start = 1; cyc(v);
      v.start = 0; cyc(v);
      cyc(v);
      rst_n = 0;
      model_reset();
      repeat (3) begin
         @(posedge clk); #1;
         check_model();
      end
      chk("rst_mid_busy", busy, 1'b0);
      chk("rst_mid_out", xlr_gpp_out, '0);
      rst_n = 1;
      v.rd_idx = 5; cyc(v);
      chk("rst_shadow5", host_rd_data, 32'h0);

      // random traffic against the model
      v = blank('0);
      for (int c = 0; c < 600; c++) begin
         if (c % 50 == 0) v.limit = TW'($urandom_range(0, 12));
         v.wr_en   = $urandom_range(0, 1);
         v.wr_idx  = IW'($urandom_range(0, NR-1));
         v.wr_data = $urandom;
         v.rd_idx  = IW'($urandom_range(0, NR-1));
         v.rd_src  = $urandom_range(0, 1);
         v.start   = ($urandom_range(0, 9) == 0);
         v.abort   = ($urandom_range(0, 29) == 0);
         v.clr     = ($urandom_range(0, 9) == 0);
         v.done    = ($urandom_range(0, 11) == 0);
         for (int k = 0; k < NR; k++) v.gin[k*DW +: DW] = $urandom;
         cyc(v);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   task automatic cyc_init();
      host_wr_en = 0; host_wr_idx = '0; host_wr_data = '0;
      host_rd_idx = '0; host_rd_src = 0;
      host_start = 0; host_abort = 0; irq_clr = 0;
      xlr_done = 0; timeout_limit = '0; xlr_gpp_in = '0;
   endtask

endmodule
